pwm_input_conditioner: RTL and testbench

Upstream front end of the PWM decode chain. Synchronises and deglitches the raw PWM input pin, produces a clean level for the `pwm_analyzer` `enable_i`, and emits rise and fall strobes. Measures the rise-to-rise period and supervises signal presence, so downstream logic knows whether the on-time being measured belongs to a plausible PWM frame.

---
 rtl/pwm_input_conditioner.sv | 149 ++++++++++++++
 tb/tb_pwm_input_conditioner.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pwm_input_conditioner.sv
// PWM input front end: synchroniser, symmetric glitch filter, edge strobes,
// rise-to-rise period measurement and signal-presence supervision.
module pwm_input_conditioner #(
    parameter  int SYNC_STAGES = 2,
    parameter  int FILTER_LEN  = 8,
    parameter  int MIN_PERIOD  = 10000,
    parameter  int MAX_PERIOD  = 30000,
    localparam int PW          = $clog2(MAX_PERIOD + 1)
) (
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic          pwm_i,
    output logic          pwm_o,
    output logic          rise_o,
    output logic          fall_o,
    output logic [PW-1:0] period_o,
    output logic          period_valid_o,
    output logic          period_err_o,
    output logic          timeout_o,
    output logic          signal_ok_o
);

    // The filter count never needs to hold FILTER_LEN itself, only FILTER_LEN-1.
    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [PW-1:0] MIN_CNT   = PW'(MIN_PERIOD);
    localparam logic [PW-1:0] MAX_CNT   = PW'(MAX_PERIOD);

    typedef enum logic [1:0] {
        LOST     = 2'd0,
        ARMED    = 2'd1,
        TRACKING = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_level;
    logic [FW-1:0]          filt_cnt;
    logic                   accept;
    logic                   rise_evt;
    logic                   fall_evt;
    logic [PW-1:0]          cnt;
    logic                   cnt_sat;
    logic                   in_range;
    state_t                 state;

    assign sync_level = sync_q[SYNC_STAGES-1];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_i};
        end
    end

    // A new level is accepted on the edge that would bring the count to FILTER_LEN.
    always_comb begin
        accept   = (sync_level != pwm_o) && (filt_cnt == FILT_LAST);
        rise_evt = accept && sync_level;
        fall_evt = accept && !sync_level;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            filt_cnt <= '0;
            pwm_o    <= 1'b0;
            rise_o   <= 1'b0;
            fall_o   <= 1'b0;
        end else begin
            rise_o <= rise_evt;
            fall_o <= fall_evt;
            if (accept) begin
                pwm_o <= sync_level;
            end
            if ((sync_level == pwm_o) || accept) begin
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

    always_comb begin
        cnt_sat  = (cnt == MAX_CNT);
        in_range = (cnt >= MIN_CNT) && (cnt < MAX_CNT);
    end

    // Rise-to-rise counter: a rise restarts at 1 so two rises N cycles apart capture N.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            cnt <= '0;
        end else if (rise_evt) begin
            cnt <= PW'(1);
        end else if (state == LOST) begin
            cnt <= '0;
        end else if (!cnt_sat) begin
            cnt <= cnt + PW'(1);
        end
    end

    // Supervisor FSM; a rise takes priority over a coincident timeout.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state          <= LOST;
            period_o       <= '0;
            period_valid_o <= 1'b0;
            period_err_o   <= 1'b0;
            timeout_o      <= 1'b0;
            signal_ok_o    <= 1'b0;
        end else begin
            period_valid_o <= 1'b0;
            period_err_o   <= 1'b0;
            timeout_o      <= 1'b0;
            case (state)
                LOST: begin
                    signal_ok_o <= 1'b0;
                    if (rise_evt) begin
                        state <= ARMED;
                    end
                end
                ARMED, TRACKING: begin
                    if (rise_evt) begin
                        period_o <= cnt;
                        if (in_range) begin
                            period_valid_o <= 1'b1;
                            state          <= TRACKING;
                            signal_ok_o    <= 1'b1;
                        end else begin
                            period_err_o <= 1'b1;
                            state        <= ARMED;
                            signal_ok_o  <= 1'b0;
                        end
                    end else if (cnt_sat) begin
                        timeout_o   <= 1'b1;
                        state       <= LOST;
                        signal_ok_o <= 1'b0;
                    end
                end
                default: begin
                    state       <= LOST;
                    signal_ok_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_input_conditioner.sv
// Directed bench for pwm_input_conditioner with SYNC_STAGES=2, FILTER_LEN=4,
// MIN_PERIOD=20, MAX_PERIOD=50; raw edges reach pwm_o six edges after sampling.
module tb_pwm_input_conditioner;

    localparam int PW = 6;

    localparam int K_NONE  = 0;
    localparam int K_VALID = 1;
    localparam int K_ERR   = 2;

    logic          clk = 1'b0;
    logic          reset_i = 1'b0;
    logic          pwm_i = 1'b0;
    logic          pwm_o;
    logic          rise_o;
    logic          fall_o;
    logic [PW-1:0] period_o;
    logic          period_valid_o;
    logic          period_err_o;
    logic          timeout_o;
    logic          signal_ok_o;

    logic [PW+6:0] all_outs;
    assign all_outs = {pwm_o, rise_o, fall_o, period_valid_o, period_err_o,
                       timeout_o, signal_ok_o, period_o};

    int n_checks = 0;
    int n_pass   = 0;
    int last_period = 0;

    always #5 clk = ~clk;

    pwm_input_conditioner #(
        .SYNC_STAGES(2),
        .FILTER_LEN (4),
        .MIN_PERIOD (20),
        .MAX_PERIOD (50)
    ) dut (
        .clock_i       (clk),
        .reset_i       (reset_i),
        .pwm_i         (pwm_i),
        .pwm_o         (pwm_o),
        .rise_o        (rise_o),
        .fall_o        (fall_o),
        .period_o      (period_o),
        .period_valid_o(period_valid_o),
        .period_err_o  (period_err_o),
        .timeout_o     (timeout_o),
        .signal_ok_o   (signal_ok_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One raw PWM cycle: high for 'high' cycles, then low for 'low' cycles.
    // The filtered rise is visible after iteration 5; the capture it makes is
    // the length of the previous call.
    task automatic pulse(input string tag, input int high, input int low, input int kind,
                         input int exp_period, input logic exp_ok, input int exp_to_idx,
                         input logic exp_ok_end);
        int to_idx = -1;
        for (int i = 0; i < high + low; i++) begin
            pwm_i = (i < high);
            tick();
            if (timeout_o && to_idx < 0) to_idx = i;
            if (i == 5) begin
                if (kind != K_NONE) last_period = exp_period;
                check({tag, " rise_o"}, rise_o, 1);
                check({tag, " valid"}, period_valid_o, (kind == K_VALID));
                check({tag, " err"}, period_err_o, (kind == K_ERR));
                check({tag, " timeout_o"}, timeout_o, 0);
                check({tag, " period_o"}, period_o, last_period);
                check({tag, " signal_ok"}, signal_ok_o, exp_ok);
            end
            if (i == 6) check({tag, " strobes one cycle"},
                              {rise_o, period_valid_o, period_err_o}, 3'b000);
            if (i == high + 4) check({tag, " pwm_o still high"}, pwm_o, 1);
            if (i == high + 5) check({tag, " fall"}, {pwm_o, fall_o}, 2'b01);
        end
        check({tag, " timeout index"}, to_idx, exp_to_idx);
        check({tag, " signal_ok end"}, signal_ok_o, exp_ok_end);
    endtask

    initial begin
        int saw;
        int rise_idx;
        int rise_cnt;
        int fall_idx;
        int to_idx;
        int ok_seen;

        // Asynchronous reset between edges clears everything at once.
        #2 reset_i = 1'b1;
        #1 check("reset async", all_outs, 0);
        repeat (3) tick();
        reset_i = 1'b0;
        saw = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (all_outs != 0) saw = 1;
        end
        check("idle after reset", saw, 0);

        // Three-cycle glitch is swallowed.
        saw = 0;
        for (int i = 0; i < 20; i++) begin
            pwm_i = (i < 3);
            tick();
            if (pwm_o || rise_o) saw = 1;
        end
        check("glitch 3 suppressed", saw, 0);

        // Four-cycle pulse passes; its lone rise arms and then times out.
        rise_idx = -1; rise_cnt = 0; fall_idx = -1; to_idx = -1; ok_seen = 0;
        for (int i = 0; i < 70; i++) begin
            pwm_i = (i < 4);
            tick();
            if (rise_o) begin
                rise_cnt++;
                if (rise_idx < 0) rise_idx = i;
            end
            if (fall_o && fall_idx < 0) fall_idx = i;
            if (timeout_o && to_idx < 0) to_idx = i;
            if (signal_ok_o || period_valid_o || period_err_o) ok_seen = 1;
        end
        check("pulse4 rise index", rise_idx, 5);
        check("pulse4 rise count", rise_cnt, 1);
        check("pulse4 fall index", fall_idx, 9);
        check("pulse4 timeout index", to_idx, 55);
        check("pulse4 no period activity", ok_seen, 0);

        // Lock onto period 30.
        pulse("lock1", 10, 20, K_NONE,  0,  1'b0, -1, 1'b0);
        pulse("lock2", 10, 20, K_VALID, 30, 1'b1, -1, 1'b1);
        pulse("lock3", 10, 20, K_VALID, 30, 1'b1, -1, 1'b1);

        // Too short, then recovery.
        pulse("short1", 4, 6,   K_VALID, 30, 1'b1, -1, 1'b1);
        pulse("short2", 4, 6,   K_ERR,   10, 1'b0, -1, 1'b0);
        pulse("restore1", 10, 20, K_ERR,   10, 1'b0, -1, 1'b0);
        pulse("restore2", 10, 20, K_VALID, 30, 1'b1, -1, 1'b1);

        // Loss of signal while tracking.
        pulse("timeout", 10, 60, K_VALID, 30, 1'b1, 55, 1'b0);
        pulse("relock1", 10, 20, K_NONE,  0,  1'b0, -1, 1'b0);
        pulse("relock2", 10, 10, K_VALID, 30, 1'b1, -1, 1'b1);

        // Period boundaries: 20 valid, 19 error, rise at cnt==50 is an error not a timeout.
        pulse("p20", 10, 9,  K_VALID, 20, 1'b1, -1, 1'b1);
        pulse("p19", 10, 40, K_ERR,   19, 1'b0, -1, 1'b0);
        pulse("p50", 10, 20, K_ERR,   50, 1'b0, -1, 1'b0);
        pulse("p30", 10, 20, K_VALID, 30, 1'b1, -1, 1'b1);

        // Reset while tracking takes effect before the next edge.
        #2 reset_i = 1'b1;
        #1 check("reset mid-run", all_outs, 0);
        tick();
        reset_i = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
